// File: rtl/frogger_pkg.sv
// Shared types and playfield constants for the river/road lane blocks.
package frogger_pkg;

    localparam int COORD_W  = 11;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_t;

    typedef enum logic {
        SURFACED  = 1'b0,
        SUBMERGED = 1'b1
    } dive_state_t;

    // One wrap check: a pad fully past either edge jumps to the other side.
    // The jump is screen_w + pad_w, so the pad re-enters with no visible gap.
    function automatic int wrap_x(input int nx, input int screen_w, input int pad_w);
        if (nx < -pad_w)
            return nx + screen_w + pad_w;
        else if (nx >= screen_w)
            return nx - (screen_w + pad_w);
        else
            return nx;
    endfunction

endpackage

// File: rtl/lily_pad_slot.sv
// One lilypad: x position register with wrap-around motion and the
// frog-versus-pad overlap test.
module lily_pad_slot
    import frogger_pkg::*;
#(
    parameter int INDEX     = 0,
    parameter int PAD_W     = 40,
    parameter int PAD_H     = 40,
    parameter int SPACING   = 200,
    parameter int STEP      = 20,
    parameter int SCREEN_W  = 640,
    parameter int X_TOL     = 5,
    parameter int Y_TOL     = 1,
    parameter int FROG_SIDE = 40
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic signed [COORD_W-1:0] start_x,
    input  logic                      step,
    input  dir_t                      direction,
    input  logic                      visible,
    input  logic signed [COORD_W-1:0] pad_y,
    input  logic signed [COORD_W-1:0] frog_x,
    input  logic signed [COORD_W-1:0] frog_y,
    output logic signed [COORD_W-1:0] x,
    output logic                      collision
);

    int init_x;
    int next_x;
    int box_l;
    int box_r;
    int box_t;
    int box_b;

    // Reset position and next-step position, both wrapped once.
    // NOTE: the arithmetic is done in 32-bit int so start_x + i*SPACING and
    // the frog box edges cannot overflow 11 bits before the wrap/compare.
    always_comb begin
        init_x = wrap_x(int'(start_x) + INDEX * SPACING, SCREEN_W, PAD_W);
        if (direction == RIGHT)
            next_x = wrap_x(int'(x) + STEP, SCREEN_W, PAD_W);
        else
            next_x = wrap_x(int'(x) - STEP, SCREEN_W, PAD_W);
    end

    // Pad x register: loads its start slot on reset, moves on step frames.
    // NOTE: the reset value comes from the start_x port, so this is an
    // asynchronous load rather than a constant clear.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset)
            x <= COORD_W'(init_x);
        else if (step)
            x <= COORD_W'(next_x);
    end

    // Shrunken frog box against the pad rectangle, inclusive and signed.
    always_comb begin
        box_l     = int'(frog_x) + X_TOL;
        box_r     = int'(frog_x) + FROG_SIDE - X_TOL;
        box_t     = int'(frog_y) + Y_TOL;
        box_b     = int'(frog_y) + FROG_SIDE - Y_TOL;
        collision = visible
                    && (box_l <= int'(x) + PAD_W) && (box_r >= int'(x))
                    && (box_t <= int'(pad_y) + PAD_H) && (box_b >= int'(pad_y));
    end

endmodule

// File: rtl/lily_lane.sv
// A lane of NUM_PADS lilypads: shared step timer, dive FSM and the carry
// pulse that lets the frog controller ride a pad.
module lily_lane
    import frogger_pkg::*;
#(
    parameter int NUM_PADS    = 3,
    parameter int PAD_W       = 40,
    parameter int PAD_H       = 40,
    parameter int SPACING     = 200,
    parameter int STEP        = 20,
    parameter int SCREEN_W    = 640,
    parameter int X_TOL       = 5,
    parameter int Y_TOL       = 1,
    parameter int FROG_SIDE   = 40,
    parameter int DIVE_PERIOD = 8,
    parameter int DIVE_LEN    = 3
) (
    input  logic                               frame_clk,
    input  logic                               Reset,
    input  logic signed [COORD_W-1:0]          start_x,
    input  logic signed [COORD_W-1:0]          start_y,
    input  logic                               direction,
    input  logic [5:0]                         speed,
    input  logic [NUM_PADS-1:0]                dive_mask,
    input  logic signed [COORD_W-1:0]          frog_x,
    input  logic signed [COORD_W-1:0]          frog_y,
    input  logic                               win,
    input  logic                               lose,
    output logic [COORD_W*NUM_PADS-1:0]        pad_x,
    output logic signed [COORD_W-1:0]          pad_y,
    output logic [COORD_W-1:0]                 pad_w,
    output logic [COORD_W-1:0]                 pad_h,
    output logic [NUM_PADS-1:0]                pad_visible,
    output logic [NUM_PADS-1:0]                pad_collision,
    output logic                               any_collision,
    output logic signed [COORD_W-1:0]          carry_dx,
    output logic                               carry_valid,
    output logic [5:0]                         wait_count
);

    localparam int  SURF_STEPS = DIVE_PERIOD - DIVE_LEN;
    localparam int  DIVE_CW    = (DIVE_PERIOD > 1) ? $clog2(DIVE_PERIOD + 1) : 1;
    localparam bit  DIVE_EN    = (DIVE_LEN != 0);

    logic               halt;
    logic               step_frame;
    dir_t               dir;
    dive_state_t        dive_state;
    logic [DIVE_CW-1:0] dive_cnt;

    assign halt       = win | lose;
    assign step_frame = !halt && (wait_count == speed);
    assign dir        = dir_t'(direction);
    assign pad_w      = COORD_W'(PAD_W);
    assign pad_h      = COORD_W'(PAD_H);

    // Idle-frame counter; lane y is latched while reset is held.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            wait_count <= '0;
            pad_y      <= start_y;
        end else if (!halt) begin
            wait_count <= step_frame ? 6'd0 : wait_count + 6'd1;
        end
    end

    // Dive FSM: surfaced for SURF_STEPS steps, submerged for DIVE_LEN steps.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            dive_state <= SURFACED;
            dive_cnt   <= '0;
        end else if (step_frame && DIVE_EN) begin
            case (dive_state)
                SURFACED: begin
                    if (dive_cnt == DIVE_CW'(SURF_STEPS - 1)) begin
                        dive_state <= SUBMERGED;
                        dive_cnt   <= '0;
                    end else begin
                        dive_cnt <= dive_cnt + 1'b1;
                    end
                end
                SUBMERGED: begin
                    if (dive_cnt == DIVE_CW'(DIVE_LEN - 1)) begin
                        dive_state <= SURFACED;
                        dive_cnt   <= '0;
                    end else begin
                        dive_cnt <= dive_cnt + 1'b1;
                    end
                end
                default: begin
                    dive_state <= SURFACED;
                    dive_cnt   <= '0;
                end
            endcase
        end
    end

    assign pad_visible   = (dive_state == SUBMERGED) ? ~dive_mask : '1;
    assign any_collision = |pad_collision;

    // Carry pulse: one frame after a step that moved a pad under the frog.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            carry_valid <= 1'b0;
            carry_dx    <= '0;
        end else if (step_frame && any_collision) begin
            carry_valid <= 1'b1;
            carry_dx    <= (dir == RIGHT) ? COORD_W'(STEP) : COORD_W'(-STEP);
        end else begin
            carry_valid <= 1'b0;
            carry_dx    <= '0;
        end
    end

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        logic signed [COORD_W-1:0] x_i;

        lily_pad_slot #(
            .INDEX     (i),
            .PAD_W     (PAD_W),
            .PAD_H     (PAD_H),
            .SPACING   (SPACING),
            .STEP      (STEP),
            .SCREEN_W  (SCREEN_W),
            .X_TOL     (X_TOL),
            .Y_TOL     (Y_TOL),
            .FROG_SIDE (FROG_SIDE)
        ) u_slot (
            .frame_clk (frame_clk),
            .Reset     (Reset),
            .start_x   (start_x),
            .step      (step_frame),
            .direction (dir),
            .visible   (pad_visible[i]),
            .pad_y     (pad_y),
            .frog_x    (frog_x),
            .frog_y    (frog_y),
            .x         (x_i),
            .collision (pad_collision[i])
        );

        assign pad_x[i*COORD_W +: COORD_W] = x_i;
    end

endmodule

// File: tb/tb_lily_lane.sv
// Self-checking bench for lily_lane with default parameters (3 pads).
module tb_lily_lane;

    localparam int FAR_X = -500;
    localparam int FAR_Y = 400;

    logic        frame_clk = 1'b0;
    logic        Reset     = 1'b1;
    logic [10:0] start_x   = '0;
    logic [10:0] start_y   = 11'd100;
    logic        direction = 1'b0;
    logic [5:0]  speed     = '0;
    logic [2:0]  dive_mask = '0;
    logic [10:0] frog_x    = 11'(FAR_X);
    logic [10:0] frog_y    = 11'(FAR_Y);
    logic        win       = 1'b0;
    logic        lose      = 1'b0;

    logic [32:0] pad_x;
    logic [10:0] pad_y, pad_w, pad_h, carry_dx;
    logic [2:0]  pad_visible, pad_collision;
    logic        any_collision, carry_valid;
    logic [5:0]  wait_count;

    lily_lane dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .start_x       (start_x),
        .start_y       (start_y),
        .direction     (direction),
        .speed         (speed),
        .dive_mask     (dive_mask),
        .frog_x        (frog_x),
        .frog_y        (frog_y),
        .win           (win),
        .lose          (lose),
        .pad_x         (pad_x),
        .pad_y         (pad_y),
        .pad_w         (pad_w),
        .pad_h         (pad_h),
        .pad_visible   (pad_visible),
        .pad_collision (pad_collision),
        .any_collision (any_collision),
        .carry_dx      (carry_dx),
        .carry_valid   (carry_valid),
        .wait_count    (wait_count)
    );

    always #5 frame_clk = ~frame_clk;

    // Expected per-frame observation; each test fills only the fields it checks.
    typedef struct {
        int x0;
        int x1;
        int wc;
        int cv;
        int dx;
        int vis;
        int col;
    } frame_exp_t;

    frame_exp_t exp_q[$];
    int passed = 0;
    int total  = 0;

    function automatic int px(input int i);
        logic [10:0] s;
        s = pad_x[i*11 +: 11];
        return int'($signed(s));
    endfunction

    function automatic int dxs();
        return int'($signed(carry_dx));
    endfunction

    task automatic do_reset(input int sx, input int sy);
        @(negedge frame_clk);
        Reset   = 1'b1;
        start_x = 11'(sx);
        start_y = 11'(sy);
        @(negedge frame_clk);
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(0, 100);
        total++; if (pad_x !== {11'd400, 11'd200, 11'd0}) $display("FAIL reset_pad_x: got %h expected %h", pad_x, {11'd400, 11'd200, 11'd0}); else passed++;
        total++; if (pad_y !== 11'd100) $display("FAIL reset_pad_y: got %0d expected 100", pad_y); else passed++;
        total++; if (wait_count !== 6'd0) $display("FAIL reset_wait_count: got %0d expected 0", wait_count); else passed++;
        total++; if (pad_visible !== 3'b111) $display("FAIL reset_visible: got %b expected 111", pad_visible); else passed++;
        total++; if (carry_valid !== 1'b0) $display("FAIL reset_carry_valid: got %b expected 0", carry_valid); else passed++;
        total++; if (carry_dx !== 11'd0) $display("FAIL reset_carry_dx: got %0d expected 0", dxs()); else passed++;
        total++; if (pad_w !== 11'd40) $display("FAIL pad_w: got %0d expected 40", pad_w); else passed++;
        total++; if (pad_h !== 11'd40) $display("FAIL pad_h: got %0d expected 40", pad_h); else passed++;
    endtask

    task automatic test_left_wrap();
        int x0_tab[9] = '{0, 0, -20, -20, -20, -40, -40, -40, 620};
        int wc_tab[9] = '{1, 2, 0, 1, 2, 0, 1, 2, 0};
        frame_exp_t e;
        speed     = 6'd2;
        direction = 1'b0;
        do_reset(0, 100);
        for (int f = 1; f <= 9; f++) begin
            e     = '{default: 0};
            e.x0  = x0_tab[f-1];
            e.x1  = 200 - 20 * (f / 3);
            e.wc  = wc_tab[f-1];
            exp_q.push_back(e);
        end
        for (int f = 1; f <= 9; f++) begin
            @(negedge frame_clk);
            e = exp_q.pop_front();
            total++; if (px(0) !== e.x0) $display("FAIL left_x0 f%0d: got %0d expected %0d", f, px(0), e.x0); else passed++;
            total++; if (px(1) !== e.x1) $display("FAIL left_x1 f%0d: got %0d expected %0d", f, px(1), e.x1); else passed++;
            total++; if (int'(wait_count) !== e.wc) $display("FAIL left_wc f%0d: got %0d expected %0d", f, wait_count, e.wc); else passed++;
        end
    endtask

    task automatic test_right_wrap();
        int x0_tab[4] = '{-40, -20, 0, 20};
        frame_exp_t e;
        speed     = 6'd0;
        direction = 1'b1;
        do_reset(620, 100);
        // 820 and 1020 exceed the screen and wrap once at reset.
        total++; if (px(0) !== 620) $display("FAIL rwrap_reset_x0: got %0d expected 620", px(0)); else passed++;
        total++; if (px(1) !== 140) $display("FAIL rwrap_reset_x1: got %0d expected 140", px(1)); else passed++;
        total++; if (px(2) !== 340) $display("FAIL rwrap_reset_x2: got %0d expected 340", px(2)); else passed++;
        for (int f = 1; f <= 4; f++) begin
            e    = '{default: 0};
            e.x0 = x0_tab[f-1];
            e.x1 = 140 + 20 * f;
            exp_q.push_back(e);
        end
        for (int f = 1; f <= 4; f++) begin
            @(negedge frame_clk);
            e = exp_q.pop_front();
            total++; if (px(0) !== e.x0) $display("FAIL right_x0 f%0d: got %0d expected %0d", f, px(0), e.x0); else passed++;
            total++; if (px(1) !== e.x1) $display("FAIL right_x1 f%0d: got %0d expected %0d", f, px(1), e.x1); else passed++;
            total++; if (carry_valid !== 1'b0) $display("FAIL right_cv f%0d: got %b expected 0", f, carry_valid); else passed++;
        end
        direction = 1'b0;
    endtask

    task automatic test_collision_carry();
        int cv_tab[7] = '{0, 0, 1, 0, 0, 1, 0};
        int dx_tab[7] = '{0, 0, -20, 0, 0, 20, 0};
        int x0_tab[7] = '{0, 0, -20, -20, -20, 0, 0};
        frame_exp_t e;
        speed     = 6'd2;
        direction = 1'b0;
        do_reset(0, 100);
        // Edge cases of the inclusive overlap with pad 0 at (0, 100).
        frog_x = 11'd36; frog_y = 11'd100; #1;
        total++; if (pad_collision !== 3'b000) $display("FAIL col_x36: got %b expected 000", pad_collision); else passed++;
        frog_x = 11'd35; #1;
        total++; if (pad_collision !== 3'b001) $display("FAIL col_x35: got %b expected 001", pad_collision); else passed++;
        total++; if (any_collision !== 1'b1) $display("FAIL any_x35: got %b expected 1", any_collision); else passed++;
        frog_x = 11'd10; frog_y = 11'd139; #1;
        total++; if (pad_collision !== 3'b001) $display("FAIL col_y139: got %b expected 001", pad_collision); else passed++;
        frog_y = 11'd140; #1;
        total++; if (pad_collision !== 3'b000) $display("FAIL col_y140: got %b expected 000", pad_collision); else passed++;
        frog_y = 11'd100;
        for (int f = 1; f <= 7; f++) begin
            e    = '{default: 0};
            e.cv = cv_tab[f-1];
            e.dx = dx_tab[f-1];
            e.x0 = x0_tab[f-1];
            exp_q.push_back(e);
        end
        for (int f = 1; f <= 7; f++) begin
            @(negedge frame_clk);
            e = exp_q.pop_front();
            total++; if (int'(carry_valid) !== e.cv) $display("FAIL carry_valid f%0d: got %0d expected %0d", f, carry_valid, e.cv); else passed++;
            total++; if (dxs() !== e.dx) $display("FAIL carry_dx f%0d: got %0d expected %0d", f, dxs(), e.dx); else passed++;
            total++; if (px(0) !== e.x0) $display("FAIL carry_x0 f%0d: got %0d expected %0d", f, px(0), e.x0); else passed++;
            total++; if (any_collision !== 1'b1) $display("FAIL carry_any f%0d: got %b expected 1", f, any_collision); else passed++;
            if (f == 4) direction = 1'b1;
        end
        direction = 1'b0;
        frog_x = 11'(FAR_X);
        frog_y = 11'(FAR_Y);
    endtask

    task automatic test_dive();
        frame_exp_t e;
        speed     = 6'd0;
        direction = 1'b0;
        dive_mask = 3'b010;
        do_reset(0, 100);
        total++; if (pad_visible !== 3'b111) $display("FAIL dive_f0_vis: got %b expected 111", pad_visible); else passed++;
        for (int k = 1; k <= 13; k++) begin
            e     = '{default: 0};
            e.vis = ((k >= 5 && k <= 7) || k == 13) ? 3'b101 : 3'b111;
            e.col = (e.vis == 3'b111) ? 3'b010 : 3'b000;
            exp_q.push_back(e);
        end
        for (int k = 1; k <= 13; k++) begin
            @(posedge frame_clk);
            #1;
            // Keep the frog on pad 1 for the first dive cycle.
            if (k <= 8) begin
                frog_x = 11'(200 - 20 * k);
                frog_y = 11'd100;
            end else begin
                frog_x = 11'(FAR_X);
                frog_y = 11'(FAR_Y);
            end
            @(negedge frame_clk);
            e = exp_q.pop_front();
            total++; if (int'(pad_visible) !== e.vis) $display("FAIL dive_vis k%0d: got %b expected %b", k, pad_visible, 3'(e.vis)); else passed++;
            if (k <= 8) begin
                total++; if (int'(pad_collision) !== e.col) $display("FAIL dive_col k%0d: got %b expected %b", k, pad_collision, 3'(e.col)); else passed++;
            end
        end
        dive_mask = '0;
    endtask

    task automatic test_halt_reset();
        int x0_tab[5] = '{0, 0, 0, 0, -20};
        int wc_tab[5] = '{1, 2, 2, 2, 0};
        int cv_tab[5] = '{0, 0, 0, 0, 1};
        frame_exp_t e;
        speed     = 6'd2;
        direction = 1'b0;
        do_reset(0, 100);
        frog_x  = 11'd10;
        frog_y  = 11'd100;
        start_y = 11'd200;
        for (int f = 1; f <= 5; f++) begin
            e    = '{default: 0};
            e.x0 = x0_tab[f-1];
            e.wc = wc_tab[f-1];
            e.cv = cv_tab[f-1];
            exp_q.push_back(e);
        end
        for (int f = 1; f <= 5; f++) begin
            @(negedge frame_clk);
            e = exp_q.pop_front();
            total++; if (px(0) !== e.x0) $display("FAIL halt_x0 f%0d: got %0d expected %0d", f, px(0), e.x0); else passed++;
            total++; if (int'(wait_count) !== e.wc) $display("FAIL halt_wc f%0d: got %0d expected %0d", f, wait_count, e.wc); else passed++;
            total++; if (int'(carry_valid) !== e.cv) $display("FAIL halt_cv f%0d: got %0d expected %0d", f, carry_valid, e.cv); else passed++;
            // Halt on the step frame with lose, then with win, then release.
            if (f == 2) lose = 1'b1;
            if (f == 3) begin lose = 1'b0; win = 1'b1; end
            if (f == 4) win = 1'b0;
        end
        total++; if (pad_y !== 11'd100) $display("FAIL halt_pad_y_held: got %0d expected 100", pad_y); else passed++;
        // Mid-cycle reset with no clock edge in between.
        #2;
        start_y = 11'd300;
        Reset   = 1'b1;
        #1;
        total++; if (px(0) !== 0) $display("FAIL async_x0: got %0d expected 0", px(0)); else passed++;
        total++; if (px(2) !== 400) $display("FAIL async_x2: got %0d expected 400", px(2)); else passed++;
        total++; if (wait_count !== 6'd0) $display("FAIL async_wc: got %0d expected 0", wait_count); else passed++;
        total++; if (carry_valid !== 1'b0) $display("FAIL async_cv: got %b expected 0", carry_valid); else passed++;
        total++; if (carry_dx !== 11'd0) $display("FAIL async_dx: got %0d expected 0", dxs()); else passed++;
        total++; if (pad_y !== 11'd300) $display("FAIL async_pad_y: got %0d expected 300", pad_y); else passed++;
        @(negedge frame_clk);
        Reset  = 1'b0;
        frog_x = 11'(FAR_X);
        frog_y = 11'(FAR_Y);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_left_wrap();
        test_right_wrap();
        test_collision_carry();
        test_dive();
        test_halt_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
